// File: rtl/wb_daq_channel_sequencer_pkg.sv
// Shared types for the DAQ channel sequencer: FSM state encoding, aggregator
// width codes and the channel-index width helper.
package wb_daq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_SELECT,
    ST_START,
    ST_CONVERT,
    ST_DELIVER
  } seq_state_e;

  localparam logic [1:0] DAQ_W8  = 2'd0;
  localparam logic [1:0] DAQ_W16 = 2'd1;
  localparam logic [1:0] DAQ_W32 = 2'd2;

  // A single-channel build still needs a one-bit index.
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_daq_channel_sequencer_if.sv
// ADC front-end handshake plus aggregator sample path of the channel sequencer.
interface wb_daq_channel_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int adc_dw = 8
);
  import wb_daq_pkg::*;

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic              adc_start;
  logic [CH_W-1:0]   adc_channel;
  logic              adc_done;
  logic [adc_dw-1:0] adc_data_in;
  logic              data_ready;
  logic [1:0]        data_width;
  logic [adc_dw-1:0] adc_data_out;

  modport master (
    output adc_start, adc_channel, data_ready, data_width, adc_data_out,
    input  adc_done, adc_data_in
  );

  modport slave (
    input  adc_start, adc_channel, data_ready, data_width, adc_data_out,
    output adc_done, adc_data_in
  );

endinterface

// File: rtl/wb_daq_channel_sequencer_prescaler.sv
// Sample-interval prescaler: reloadable down-counter, one-cycle tick every
// prescale+1 cycles, held at the reload value while clear is high.
module wb_daq_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  assign tick = !clear && (count == '0);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= prescale;
    end else begin
      count <= count - PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/wb_daq_channel_sequencer.sv
// Tick-driven ADC channel scan controller feeding the DAQ aggregator.
// Optional conversion watchdog: define WB_DAQ_SEQ_TIMEOUT_EN.
module wb_daq_channel_sequencer
  import wb_daq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int adc_dw      = 8,
  parameter int PRESCALE_W  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [1:0]            width_cfg,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_status,
  input  logic                  fifo_full,
  wb_daq_channel_sequencer_if.master bus,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  seq_state_e        state;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] cur_bit;
  logic [CH_W-1:0]   cur_ch;
  logic              start_pulse;
  logic              ready_pulse;
  logic [1:0]        width_lock;
  logic [adc_dw-1:0] sample;
  logic              abort;
  logic              tick;
  logic              scan_active;
  logic              ovr_set;
  logic              wd_expired;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [1:0] width_code(input logic [1:0] cfg);
    return (cfg == 2'd3) ? DAQ_W8 : cfg;
  endfunction

  wb_daq_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .clear    (state == ST_IDLE),
    .prescale (prescale),
    .tick     (tick)
  );

  assign cur_bit     = NUM_CH'(1) << cur_ch;
  assign scan_active = (state == ST_SELECT) || (state == ST_START) ||
                       (state == ST_CONVERT) || (state == ST_DELIVER);
  // A tick during a scan, or one refused because the FIFO is full, is lost.
  assign ovr_set     = tick && (scan_active ||
                       ((state == ST_WAIT_TICK) && enable && (|ch_enable) && fifo_full));

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (clr_status) begin
      overrun <= 1'b0;
    end
  end

`ifdef WB_DAQ_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd;
  logic            timeout_flag;

  assign wd_expired = (state == ST_CONVERT) && !bus.adc_done &&
                      (wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd           <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wd <= (state == ST_CONVERT) ? wd + WD_W'(1) : '0;
      if (wd_expired) begin
        timeout_flag <= 1'b1;
      end else if (clr_status) begin
        timeout_flag <= 1'b0;
      end
    end
  end

  assign timeout = timeout_flag;
`else
  assign wd_expired = 1'b0;
  // Watchdog compiled out: the flag is a constant 0.
  assign timeout    = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state       <= ST_IDLE;
      mask        <= '0;
      cur_ch      <= '0;
      start_pulse <= 1'b0;
      ready_pulse <= 1'b0;
      width_lock  <= DAQ_W8;
      sample      <= '0;
      abort       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      ready_pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (enable) begin
            width_lock <= width_code(width_cfg);
            state      <= ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (tick && (|ch_enable) && !fifo_full) begin
            mask   <= ch_enable;
            cur_ch <= lowest_ch(ch_enable);
            busy   <= 1'b1;
            state  <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (mask == '0) begin
            busy  <= 1'b0;
            state <= ST_WAIT_TICK;
          end else begin
            cur_ch      <= lowest_ch(mask);
            start_pulse <= 1'b1;
            state       <= ST_START;
          end
        end
        ST_START: begin
          abort <= 1'b0;
          if (!enable) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          // Once disabled, the in-flight conversion is drained but never delivered.
          abort <= abort | !enable;
          if (bus.adc_done || wd_expired) begin
            mask <= mask & ~cur_bit;
            if (abort || !enable) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (bus.adc_done) begin
              sample      <= bus.adc_data_in;
              ready_pulse <= 1'b1;
              state       <= ST_DELIVER;
            end else begin
              if (|(mask & ~cur_bit)) cur_ch <= lowest_ch(mask & ~cur_bit);
              state <= ST_SELECT;
            end
          end
        end
        ST_DELIVER: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (|mask) cur_ch <= lowest_ch(mask);
            state <= ST_SELECT;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.adc_start    = start_pulse;
  assign bus.adc_channel  = cur_ch;
  assign bus.data_ready   = ready_pulse;
  assign bus.data_width   = width_lock;
  assign bus.adc_data_out = sample;

endmodule

// File: tb/tb_wb_daq_channel_sequencer.sv
// Directed bench for wb_daq_channel_sequencer with a behavioural ADC responder.
module tb_wb_daq_channel_sequencer;

  logic        wb_clk;
  logic        wb_rst_n;
  logic        enable;
  logic [3:0]  ch_enable;
  logic [1:0]  width_cfg;
  logic [15:0] prescale;
  logic        clr_status;
  logic        fifo_full;
  logic        busy;
  logic        overrun;
  logic        timeout;

  wb_daq_channel_sequencer_if #(.NUM_CH(4), .adc_dw(8)) bus ();

  wb_daq_channel_sequencer #(
    .NUM_CH(4), .adc_dw(8), .PRESCALE_W(16), .TIMEOUT_CYC(20)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .enable     (enable),
    .ch_enable  (ch_enable),
    .width_cfg  (width_cfg),
    .prescale   (prescale),
    .clr_status (clr_status),
    .fifo_full  (fifo_full),
    .bus        (bus),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // ADC responder: done pulses adc_lat cycles after start, data = C0 | channel.
  int   adc_lat  = 5;
  logic mute_ch0 = 1'b0;

  initial begin
    logic [1:0] ch;
    bus.adc_done    = 1'b0;
    bus.adc_data_in = 8'h00;
    forever begin
      @(posedge wb_clk);
      #1;
      bus.adc_done = 1'b0;
      if (bus.adc_start && !(mute_ch0 && bus.adc_channel == 2'd0)) begin
        ch = bus.adc_channel;
        repeat (adc_lat) @(posedge wb_clk);
        #1;
        bus.adc_done    = 1'b1;
        bus.adc_data_in = 8'hC0 | {6'b0, ch};
      end
    end
  end

  // Event log sampled mid-cycle, after DUT outputs and ADC inputs settle.
  int         cyc_no   = 0;
  int         n_start  = 0;
  int         n_rdy    = 0;
  int         bad_lat  = 0;
  logic       prev_done = 1'b0;
  logic [1:0] start_ch [16];
  int         start_cyc [16];
  logic [7:0] rdy_dat [16];

  initial begin
    forever begin
      @(posedge wb_clk);
      #3;
      cyc_no++;
      if (bus.adc_start) begin
        if (n_start < 16) begin
          start_ch[n_start]  = bus.adc_channel;
          start_cyc[n_start] = cyc_no;
        end
        n_start++;
      end
      if (bus.data_ready) begin
        if (n_rdy < 16) rdy_dat[n_rdy] = bus.adc_data_out;
        if (!prev_done) bad_lat++;
        n_rdy++;
      end
      prev_done = bus.adc_done;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic clr_log();
    n_start = 0;
    n_rdy   = 0;
    bad_lat = 0;
  endtask

  task automatic wait_rdy(input int n, input int budget);
    for (int i = 0; i < budget && n_rdy < n; i++) @(negedge wb_clk);
  endtask

  task automatic wait_start(input int n, input int budget);
    for (int i = 0; i < budget && n_start < n; i++) @(negedge wb_clk);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    cyc(20);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
  endtask

  initial begin
    wb_rst_n   = 1'b0;
    enable     = 1'b0;
    ch_enable  = 4'b0000;
    width_cfg  = 2'd0;
    prescale   = 16'd0;
    clr_status = 1'b0;
    fifo_full  = 1'b0;
    cyc(3);

    chk("rst_adc_start", bus.adc_start, 0);
    chk("rst_adc_channel", bus.adc_channel, 0);
    chk("rst_data_ready", bus.data_ready, 0);
    chk("rst_data_width", bus.data_width, 0);
    chk("rst_adc_data_out", bus.adc_data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    wb_rst_n = 1'b1;
    cyc(2);

    // Basic scan over channels 1 and 3.
    ch_enable = 4'b1010;
    prescale  = 16'd99;
    adc_lat   = 5;
    clr_log();
    enable = 1'b1;
    wait_rdy(2, 200);
    chk("scan_ready_cnt", n_rdy, 2);
    chk("scan_start_cnt", n_start, 2);
    chk("scan_ch_first", start_ch[0], 1);
    chk("scan_ch_second", start_ch[1], 3);
    chk("scan_data_first", rdy_dat[0], 8'hC1);
    chk("scan_data_second", rdy_dat[1], 8'hC3);
    chk("scan_ready_after_done", bad_lat, 0);
    cyc(3);
    chk("scan_idle_busy", busy, 0);
    cyc(107);
    chk("scan_second_tick_cnt", n_rdy, 4);
    chk("scan_no_overrun", overrun, 0);

    // Width lock across a mid-run width_cfg change.
    go_idle();
    width_cfg = 2'd1;
    enable = 1'b1;
    cyc(3);
    chk("width_latched", bus.data_width, 1);
    width_cfg = 2'd2;
    cyc(20);
    chk("width_held_run", bus.data_width, 1);
    enable = 1'b0;
    cyc(3);
    chk("width_held_idle", bus.data_width, 1);
    chk("width_idle_busy", busy, 0);
    enable = 1'b1;
    cyc(3);
    chk("width_relatched", bus.data_width, 2);
    enable = 1'b0;
    width_cfg = 2'd3;
    cyc(2);
    enable = 1'b1;
    cyc(3);
    chk("width_reserved", bus.data_width, 0);

    // Overrun: ticks every 4 cycles against a 10-cycle conversion.
    go_idle();
    ch_enable = 4'b0001;
    prescale  = 16'd3;
    adc_lat   = 10;
    width_cfg = 2'd0;
    clr_log();
    enable = 1'b1;
    wait_rdy(1, 50);
    chk("ovr_ready_cnt", n_rdy, 1);
    chk("ovr_flag", overrun, 1);
    wait_start(2, 60);
    chk("ovr_start_cnt", n_start, 2);
    chk("ovr_start_gap", start_cyc[1] - start_cyc[0], 16);
    enable = 1'b0;
    cyc(3);
    chk("ovr_sticky", overrun, 1);
    pulse_clr();
    chk("ovr_cleared", overrun, 0);

    // FIFO full at the tick drops the scan.
    go_idle();
    pulse_clr();
    prescale  = 16'd9;
    adc_lat   = 2;
    fifo_full = 1'b1;
    clr_log();
    enable = 1'b1;
    cyc(15);
    chk("fifo_no_start", n_start, 0);
    chk("fifo_overrun", overrun, 1);
    fifo_full = 1'b0;
    cyc(12);
    chk("fifo_resume_start", n_start, 1);
    chk("fifo_resume_ready", n_rdy, 1);
    chk("fifo_resume_data", rdy_dat[0], 8'hC0);

    // Disable while converting: sample drained, not delivered.
    go_idle();
    pulse_clr();
    adc_lat = 10;
    clr_log();
    enable = 1'b1;
    wait_start(1, 30);
    chk("dis_start_cnt", n_start, 1);
    cyc(2);
    enable = 1'b0;
    cyc(3);
    chk("dis_busy_waiting", busy, 1);
    cyc(5);
    chk("dis_done_seen", bus.adc_done, 1);
    cyc(1);
    chk("dis_busy_cleared", busy, 0);
    chk("dis_no_ready", n_rdy, 0);
    cyc(5);
    chk("dis_no_restart", n_start, 1);

`ifdef WB_DAQ_SEQ_TIMEOUT_EN
    // Watchdog: channel 0 never answers, channel 1 still delivered.
    go_idle();
    ch_enable = 4'b0011;
    prescale  = 16'd99;
    adc_lat   = 3;
    mute_ch0  = 1'b1;
    clr_log();
    enable = 1'b1;
    wait_rdy(1, 200);
    chk("to_flag", timeout, 1);
    chk("to_ready_cnt", n_rdy, 1);
    chk("to_data", rdy_dat[0], 8'hC1);
    chk("to_ch_first", start_ch[0], 0);
    chk("to_ch_second", start_ch[1], 1);
    chk("to_start_gap", start_cyc[1] - start_cyc[0], 22);
    enable   = 1'b0;
    mute_ch0 = 1'b0;
    cyc(3);
    pulse_clr();
    chk("to_cleared", timeout, 0);
`else
    chk("timeout_tied_low", timeout, 0);
`endif

    // Asynchronous reset in the middle of a conversion.
    go_idle();
    ch_enable = 4'b1000;
    prescale  = 16'd5;
    adc_lat   = 4;
    width_cfg = 2'd1;
    clr_log();
    enable = 1'b1;
    wait_start(1, 30);
    cyc(1);
    chk("mid_busy", busy, 1);
    chk("mid_channel", bus.adc_channel, 3);
    wb_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_channel", bus.adc_channel, 0);
    chk("mid_rst_width", bus.data_width, 0);
    chk("mid_rst_ready", bus.data_ready, 0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
